logical_arbiter: RTL and testbench
==================================

# logical_arbiter

Shares a single `logical_unit` instance among `NUM_REQ` requesters. Requests are granted round-robin, one issue per cycle, and the unit's operand and control inputs are driven from a register stage. Each response is captured into a per-requester result slot held until that requester accepts it. The block sits between the SMC lane schedulers and the logical datapath and is the only driver of the unit's inputs.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `DW`, 32, operand/result width; fixed to 32 by the unit.
- `clk` in 1, single clock.
- `rst_n` in 1, asynchronous active-low reset.
- `req_vld_i` in NUM_REQ, per-requester request valid.
- `req_rdy_o` out NUM_REQ, grant; a handshake occurs when both valid and ready are high at a posedge.
- `req_op_i` in 4*NUM_REQ, opcode, slice i = [4i+3:4i].
- `req_prec_i` in NUM_REQ, 0 = 16-bit, 1 = 32-bit.
- `req_dir_i` in NUM_REQ, shift direction, 0 = left, 1 = right.
- `req_src0_i`, `req_src1_i` in 32*NUM_REQ, operands.
- `req_status_i` in 3*NUM_REQ, fpadd status {gt,eq,ls} for select ops.
- `resp_vld_o` out NUM_REQ, result slot full.
- `resp_rdy_i` in NUM_REQ, requester accepts result.
- `resp_data_o` out 32*NUM_REQ, slot contents.
- `lu_vld_o`, `lu_op_o`[3:0], `lu_prec_o`, `lu_dir_o`, `lu_src0_o`[31:0], `lu_src1_o`[31:0], `lu_status_o`[2:0]: out, registered unit inputs.
- `lu_done_i` in 1, unit done.
- `lu_dst_i` in 32, unit result.
- `err_o` out 1, sticky protocol error.

## Operation
- **Busy bits.** `busy[i]` is set on requester i's grant and cleared on its `resp_vld_o & resp_rdy_i` handshake. Each requester has at most one outstanding operation.
- **Eligibility.** `elig[i] = req_vld_i[i] & ~busy[i]`. A busy bit cleared at an edge makes its requester eligible from the next cycle only.
- **Grant.** Combinational one-hot grant `req_rdy_o` over `elig`. Priority starts at `last+1` modulo `NUM_REQ`. `last` updates to the granted index on each grant and holds when there is no grant.
- **Issue stage (S1).** On a grant, register the requester's op/prec/dir/src0/src1/status into `lu_*`, set `lu_vld_o=1`, and set `tag1` to the grant index. With no grant, `lu_vld_o=0` and the `lu_*` data holds its previous value.
- **Wait stage (S2).** `vld2 <= lu_vld_o`, `tag2 <= tag1`.
- **Capture.** When `vld2 & lu_done_i`, write `lu_dst_i` into `slot[tag2]` and set `resp_vld_o[tag2]`. Slots are never overwritten: the busy rule guarantees the target slot is empty.
- **Error.** `err_o` sets when `lu_done_i != vld2` at any posedge and clears only on reset. A mismatched done is discarded.
- **Pass-through.** Opcodes are not decoded; illegal opcodes pass through and return 0 from the unit.
- **Reset.** Asserting reset mid-operation clears in-flight ops and slots; their responses are lost.

## Timing
- **Reset values.** All outputs are 0: `req_rdy_o`, `resp_vld_o`, `resp_data_o`, `lu_*`, `err_o`. Internally `last = NUM_REQ-1`, so requester 0 wins first, and `busy = 0`, `vld2 = 0`.
- **Latency.** A request accepted in cycle 0 gives `lu_vld_o` in cycle 1, `lu_done_i` in cycle 2, and `resp_vld_o` in cycle 3.
- **Throughput.** One issue per cycle when different requesters are eligible.
- **Single requester.** Minimum issue-to-issue spacing is 4 cycles when the response is accepted in its first valid cycle.
- **Response hold.** `resp_vld_o`/`resp_data_o` hold stable until accepted. Capture and accept never collide on the same slot.
- **Requester protocol.** Requesters must hold `req_*` stable while `req_vld_i` is high and ungranted. The grant depends combinationally on `req_vld_i`, so no loop through `req_rdy_o` is allowed upstream.

## Structure
- **Package `logical_pkg`.** Holds the opcode localparams (AND=0 .. ROT_SHIFT=10), the precision and direction encodings, and the status bit indices (GT=2, EQ=1, LS=0), shared with `logical_unit`.
- **Sub-module `rr_arbiter`.** Parameterised on `NUM_REQ`. Inputs are `elig` and `last`; outputs are the one-hot grant and its encoded index. Purely combinational.
- **Top level.** Contains the busy bits, S1/S2 registers, the slots, and `err_o`.

## Test plan
1. **Single AND.** Reset, then requester 0 sends AND with prec=1, src0=0xF0F0_1234, src1=0x0FF0_FFFF. Expect `lu_vld_o` in cycle 1, and `resp_vld_o[0]` with 0x00F0_1234 in cycle 3.
2. **All four contending.** All 4 requesters request continuously. Expect grants in order 0,1,2,3 on consecutive cycles, each response routed to its own slot. Requester 3's 16-bit ROT with src0=0x0000_0001, src1=1 returns 0x0000_8000.
3. **Backpressure.** Requester 1 holds `resp_rdy_i=0` for 10 cycles while re-requesting. Expect `req_rdy_o[1]=0` throughout, others still served, and the slot data stable. Accept in cycle k: `req_rdy_o[1]` is possible no earlier than k+1.
4. **Fairness after idle.** Grant requester 2, then requesters 1 and 3 request together. Expect 3 to be granted before 1.
5. **Reset mid-flight.** Pulse `rst_n` low while S1/S2 hold ops and slot 0 is full. Expect all outputs 0 immediately, no stale response afterwards, and requester 0 winning first.
6. **Protocol error.** Force `lu_done_i=1` with no op issued. Expect `err_o=1` sticky, all `resp_vld_o` unchanged.

Source files
------------

// File: rtl/logical_pkg.sv
// Encodings shared by the logical arbiter and logical_unit: opcodes, precision, shift direction, status bits.
// Also holds the packed record that the arbiter registers into the unit's input stage.
package logical_pkg;

   localparam logic [3:0] OP_AND         = 4'd0;
   localparam logic [3:0] OP_OR          = 4'd1;
   localparam logic [3:0] OP_XOR         = 4'd2;
   localparam logic [3:0] OP_NOT         = 4'd3;
   localparam logic [3:0] OP_PASS        = 4'd4;
   localparam logic [3:0] OP_SEL_GT      = 4'd5;
   localparam logic [3:0] OP_SEL_EQ      = 4'd6;
   localparam logic [3:0] OP_SEL_LS      = 4'd7;
   localparam logic [3:0] OP_SHIFT       = 4'd8;
   localparam logic [3:0] OP_ARITH_SHIFT = 4'd9;
   localparam logic [3:0] OP_ROT_SHIFT   = 4'd10;

   localparam logic PREC_16   = 1'b0;
   localparam logic PREC_32   = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int ST_GT = 2;
   localparam int ST_EQ = 1;
   localparam int ST_LS = 0;

   localparam int LU_DW = 32;

   typedef struct packed {
      logic [3:0]       op;
      logic             prec;
      logic             dir;
      logic [LU_DW-1:0] src0;
      logic [LU_DW-1:0] src1;
      logic [2:0]       status;
   } lu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over elig_i, searching upward from last_i+1 (mod NUM_REQ).
// Zero latency; no state, so any backpressure is expressed by the caller through elig_i.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         elig_i,
   input  logic [$clog2(NUM_REQ)-1:0] last_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       vld_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int PW = IW + 1;

   logic [PW-1:0] pos;

   // Walk from the farthest candidate to the nearest so the closest eligible one overrides.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      pos   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         pos = {1'b0, last_i} + PW'(k);
         if (pos >= PW'(NUM_REQ)) begin
            pos = pos - PW'(NUM_REQ);
         end
         if (elig_i[pos[IW-1:0]]) begin
            gnt_o                = '0;
            gnt_o[pos[IW-1:0]]   = 1'b1;
            idx_o                = pos[IW-1:0];
         end
      end
   end

   assign vld_o = |elig_i;

endmodule

// File: rtl/logical_arbiter.sv
// Shares one logical_unit among NUM_REQ requesters: grant same cycle, lu_* next cycle, result slot valid 3 cycles after grant.
// A requester with an unaccepted result slot is not granted again, so slots never overflow and resp_* holds until accepted.
module logical_arbiter
   import logical_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DW      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_vld_i,
   output logic [NUM_REQ-1:0]    req_rdy_o,
   input  logic [4*NUM_REQ-1:0]  req_op_i,
   input  logic [NUM_REQ-1:0]    req_prec_i,
   input  logic [NUM_REQ-1:0]    req_dir_i,
   input  logic [DW*NUM_REQ-1:0] req_src0_i,
   input  logic [DW*NUM_REQ-1:0] req_src1_i,
   input  logic [3*NUM_REQ-1:0]  req_status_i,
   output logic [NUM_REQ-1:0]    resp_vld_o,
   input  logic [NUM_REQ-1:0]    resp_rdy_i,
   output logic [DW*NUM_REQ-1:0] resp_data_o,
   output logic                  lu_vld_o,
   output logic [3:0]            lu_op_o,
   output logic                  lu_prec_o,
   output logic                  lu_dir_o,
   output logic [DW-1:0]         lu_src0_o,
   output logic [DW-1:0]         lu_src1_o,
   output logic [2:0]            lu_status_o,
   input  logic                  lu_done_i,
   input  logic [DW-1:0]         lu_dst_i,
   output logic                  err_o
);

   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] busy_q, busy_d;
   logic [NUM_REQ-1:0] resp_vld_q, resp_vld_d;
   logic [NUM_REQ-1:0] elig, gnt, resp_hs, cap_vec;
   logic [IW-1:0]      last_q, gnt_idx, tag1_q, tag2_q;
   logic               gnt_vld, lu_vld_q, vld2_q, err_q, cap;
   lu_req_t            lu_q, sel_req;
   logic [DW-1:0]      slot_q [NUM_REQ];

   // Gated by rst_n so no grant is visible while the block is held in reset.
   assign elig = req_vld_i & ~busy_q & {NUM_REQ{rst_n}};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .elig_i (elig),
      .last_i (last_q),
      .gnt_o  (gnt),
      .idx_o  (gnt_idx),
      .vld_o  (gnt_vld)
   );

   assign req_rdy_o = gnt;

   always_comb begin
      sel_req        = '0;
      sel_req.op     = req_op_i[4*int'(gnt_idx) +: 4];
      sel_req.prec   = req_prec_i[gnt_idx];
      sel_req.dir    = req_dir_i[gnt_idx];
      sel_req.src0   = req_src0_i[DW*int'(gnt_idx) +: DW];
      sel_req.src1   = req_src1_i[DW*int'(gnt_idx) +: DW];
      sel_req.status = req_status_i[3*int'(gnt_idx) +: 3];
   end

   // A done without a matching op in S2 only raises err_o; it never touches a slot.
   assign cap        = vld2_q & lu_done_i;
   assign cap_vec    = cap ? (NUM_REQ'(1) << tag2_q) : '0;
   assign resp_hs    = resp_vld_q & resp_rdy_i;
   assign busy_d     = (busy_q | gnt) & ~resp_hs;
   assign resp_vld_d = (resp_vld_q & ~resp_rdy_i) | cap_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         last_q     <= IW'(NUM_REQ-1);
         lu_vld_q   <= 1'b0;
         lu_q       <= '0;
         tag1_q     <= '0;
         vld2_q     <= 1'b0;
         tag2_q     <= '0;
         resp_vld_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         busy_q     <= busy_d;
         resp_vld_q <= resp_vld_d;
         lu_vld_q   <= gnt_vld;
         vld2_q     <= lu_vld_q;
         tag2_q     <= tag1_q;
         if (gnt_vld) begin
            lu_q   <= sel_req;
            tag1_q <= gnt_idx;
            last_q <= gnt_idx;
         end
         if (cap) begin
            slot_q[tag2_q] <= lu_dst_i;
         end
         if (lu_done_i != vld2_q) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      resp_data_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_data_o[DW*i +: DW] = slot_q[i];
      end
   end

   assign resp_vld_o  = resp_vld_q;
   assign lu_vld_o    = lu_vld_q;
   assign lu_op_o     = lu_q.op;
   assign lu_prec_o   = lu_q.prec;
   assign lu_dir_o    = lu_q.dir;
   assign lu_src0_o   = lu_q.src0;
   assign lu_src1_o   = lu_q.src1;
   assign lu_status_o = lu_q.status;
   assign err_o       = err_q;

endmodule

// File: tb/tb_logical_arbiter.sv
// Bench for logical_arbiter: a behavioural logical_unit answers each issue one cycle after lu_vld_o,
// and a timestamp-based requester model predicts grants, result slots and the error flag every cycle.
module tb_logical_arbiter;
   import logical_pkg::*;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_vld_i, req_rdy_o, req_prec_i, req_dir_i;
   logic [N-1:0]     resp_vld_o, resp_rdy_i;
   logic [4*N-1:0]   req_op_i;
   logic [32*N-1:0]  req_src0_i, req_src1_i, resp_data_o;
   logic [3*N-1:0]   req_status_i;
   logic             lu_vld_o, lu_prec_o, lu_dir_o, lu_done_i, err_o;
   logic [3:0]       lu_op_o;
   logic [31:0]      lu_src0_o, lu_src1_o, lu_dst_i;
   logic [2:0]       lu_status_o;

   int pass_cnt = 0;
   int tot_cnt  = 0;
   bit force_done = 1'b0;

   always #5 clk = ~clk;

   logical_arbiter #(.NUM_REQ(N), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
      .req_prec_i(req_prec_i), .req_dir_i(req_dir_i),
      .req_src0_i(req_src0_i), .req_src1_i(req_src1_i), .req_status_i(req_status_i),
      .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_data_o(resp_data_o),
      .lu_vld_o(lu_vld_o), .lu_op_o(lu_op_o), .lu_prec_o(lu_prec_o), .lu_dir_o(lu_dir_o),
      .lu_src0_o(lu_src0_o), .lu_src1_o(lu_src1_o), .lu_status_o(lu_status_o),
      .lu_done_i(lu_done_i), .lu_dst_i(lu_dst_i), .err_o(err_o)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] unit_fn(input logic [3:0] op, input logic prec, input logic dir,
                                           input logic [31:0] a, input logic [31:0] b, input logic [2:0] st);
      logic [31:0] m, x, y, r;
      int w, sh;
      m  = prec ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      w  = prec ? 32 : 16;
      sh = prec ? int'(b[4:0]) : int'(b[3:0]);
      x  = a & m;
      y  = b & m;
      r  = '0;
      case (op)
         OP_AND:    r = x & y;
         OP_OR:     r = x | y;
         OP_XOR:    r = x ^ y;
         OP_NOT:    r = ~x;
         OP_PASS:   r = x;
         OP_SEL_GT: r = st[ST_GT] ? x : y;
         OP_SEL_EQ: r = st[ST_EQ] ? x : y;
         OP_SEL_LS: r = st[ST_LS] ? x : y;
         OP_SHIFT:  r = dir ? (x >> sh) : (x << sh);
         OP_ARITH_SHIFT: begin
            if (dir) begin
               r = x;
               for (int k = 0; k < sh; k++) r = (r >> 1) | ({31'b0, x[w-1]} << (w-1));
            end else begin
               r = x << sh;
            end
         end
         OP_ROT_SHIFT: r = dir ? ((x >> sh) | (x << (w - sh))) : ((x << sh) | (x >> (w - sh)));
         default:   r = '0;
      endcase
      return r & m;
   endfunction

   // Behavioural logical_unit: answers exactly one cycle after it sees lu_vld_o.
   bit          pend;
   logic [31:0] pend_dst;
   initial begin
      lu_done_i = 1'b0;
      lu_dst_i  = '0;
      pend      = 1'b0;
      pend_dst  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend      = 1'b0;
            lu_done_i = 1'b0;
         end else begin
            lu_done_i = pend | force_done;
            if (pend) lu_dst_i = pend_dst;
            pend     = lu_vld_o;
            pend_dst = unit_fn(lu_op_o, lu_prec_o, lu_dir_o, lu_src0_o, lu_src1_o, lu_status_o);
         end
      end
   end

   // Requester-level model: result i is expected from grant cycle + 3 until accepted.
   int          t, m_last, m_prev;
   int          m_ready [N];
   bit          m_busy  [N];
   logic [31:0] m_data  [N];
   bit          m_err;
   logic [N-1:0] m_gvec;
   logic [3:0]  p_op;
   logic        p_prec, p_dir;
   logic [31:0] p_s0, p_s1;
   logic [2:0]  p_st;

   task automatic model_reset();
      t = 0; m_last = N-1; m_prev = -1; m_err = 1'b0; m_gvec = '0;
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0; m_ready[i] = 0; m_data[i] = '0;
      end
   endtask

   function automatic logic [255:0] all_outs();
      return 256'({req_rdy_o, resp_vld_o, resp_data_o, lu_vld_o, lu_op_o, lu_prec_o, lu_dir_o,
                   lu_src0_o, lu_src1_o, lu_status_o, err_o});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one cycle against the model at the falling edge, then advance the model past the next rising edge.
   task automatic step();
      int g, j;
      logic [N-1:0] eg, erv;
      @(negedge clk);
      g = -1;
      for (int k = 1; k <= N; k++) begin
         j = (m_last + k) % N;
         if (g < 0 && req_vld_i[j] && !m_busy[j]) g = j;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      for (int i = 0; i < N; i++) erv[i] = m_busy[i] && (t >= m_ready[i]);
      check("req_rdy", 256'(req_rdy_o), 256'(eg));
      check("resp_vld", 256'(resp_vld_o), 256'(erv));
      for (int i = 0; i < N; i++)
         if (erv[i]) check($sformatf("resp_data[%0d]", i), 256'(resp_data_o[32*i +: 32]), 256'(m_data[i]));
      check("lu_vld", 256'(lu_vld_o), 256'(m_prev >= 0));
      if (m_prev >= 0)
         check("lu_fields", 256'({lu_op_o, lu_prec_o, lu_dir_o, lu_src0_o, lu_src1_o, lu_status_o}),
               256'({p_op, p_prec, p_dir, p_s0, p_s1, p_st}));
      check("err", 256'(err_o), 256'(m_err));
      for (int i = 0; i < N; i++)
         if (erv[i] && resp_rdy_i[i]) m_busy[i] = 1'b0;
      if (g >= 0) begin
         p_op   = req_op_i[4*g +: 4];
         p_prec = req_prec_i[g];
         p_dir  = req_dir_i[g];
         p_s0   = req_src0_i[32*g +: 32];
         p_s1   = req_src1_i[32*g +: 32];
         p_st   = req_status_i[3*g +: 3];
         m_busy[g]  = 1'b1;
         m_ready[g] = t + 3;
         m_data[g]  = unit_fn(p_op, p_prec, p_dir, p_s0, p_s1, p_st);
         m_last     = g;
      end
      m_prev = g;
      m_gvec = eg;
      if (force_done) m_err = 1'b1;
      t++;
   endtask

   task automatic cyc();
      step();
      tick();
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic prec, input logic dir,
                          input logic [31:0] s0, input logic [31:0] s1, input logic [2:0] st);
      req_vld_i[i]            = v;
      req_op_i[4*i +: 4]      = op;
      req_prec_i[i]           = prec;
      req_dir_i[i]            = dir;
      req_src0_i[32*i +: 32]  = s0;
      req_src1_i[32*i +: 32]  = s1;
      req_status_i[3*i +: 3]  = st;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_vld_i  = '0;
      resp_rdy_i = '0;
      force_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_contenders();
      set_req(0, 1'b1, OP_AND,       PREC_32, DIR_LEFT,  32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000);
      set_req(1, 1'b1, OP_OR,        PREC_32, DIR_LEFT,  32'h1234_0000, 32'h0000_5678, 3'b000);
      set_req(2, 1'b1, OP_XOR,       PREC_16, DIR_LEFT,  32'hFFFF_00FF, 32'h0000_FFFF, 3'b000);
      set_req(3, 1'b1, OP_ROT_SHIFT, PREC_16, DIR_RIGHT, 32'h0000_0001, 32'h0000_0001, 3'b000);
   endtask

   typedef struct packed {
      logic [N-1:0] vld;
      logic [N-1:0] rr;
      logic [N-1:0] rdy;
      logic [N-1:0] rv;
   } vec_t;

   initial begin
      vec_t        tbl [12];
      logic [31:0] tdat [N];
      logic [31:0] held;

      tbl[0]  = '{4'b1111, 4'b1111, 4'b0001, 4'b0000};
      tbl[1]  = '{4'b1111, 4'b1111, 4'b0010, 4'b0000};
      tbl[2]  = '{4'b1111, 4'b1111, 4'b0100, 4'b0000};
      tbl[3]  = '{4'b1111, 4'b1111, 4'b1000, 4'b0001};
      tbl[4]  = '{4'b1111, 4'b1111, 4'b0001, 4'b0010};
      tbl[5]  = '{4'b1111, 4'b1111, 4'b0010, 4'b0100};
      tbl[6]  = '{4'b1111, 4'b1111, 4'b0100, 4'b1000};
      tbl[7]  = '{4'b1111, 4'b1111, 4'b1000, 4'b0001};
      tbl[8]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0010};
      tbl[9]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0100};
      tbl[10] = '{4'b0000, 4'b1111, 4'b0000, 4'b1000};
      tbl[11] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
      tdat[0] = 32'h00F0_1234;
      tdat[1] = 32'h1234_5678;
      tdat[2] = 32'h0000_FF00;
      tdat[3] = 32'h0000_8000;

      rst_n = 1'b0; req_vld_i = '0; resp_rdy_i = '0; req_op_i = '0; req_prec_i = '0; req_dir_i = '0;
      req_src0_i = '0; req_src1_i = '0; req_status_i = '0;
      model_reset();
      @(posedge clk);
      #1 check("reset_outputs", all_outs(), 256'(0));

      // Single AND on requester 0.
      do_reset();
      cyc();
      set_req(0, 1'b1, OP_AND, PREC_32, DIR_LEFT, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000);
      step(); check("t1_grant0", 256'(req_rdy_o), 256'(4'b0001)); tick();
      req_vld_i[0] = 1'b0;
      step(); check("t1_lu_vld", 256'({lu_vld_o, lu_op_o, lu_src0_o}), 256'({1'b1, OP_AND, 32'hF0F0_1234})); tick();
      step(); check("t1_no_resp_yet", 256'(resp_vld_o), 256'(0)); tick();
      step(); check("t1_resp", 256'({resp_vld_o[0], resp_data_o[31:0]}), 256'({1'b1, 32'h00F0_1234})); tick();
      resp_rdy_i[0] = 1'b1;
      cyc();
      step(); check("t1_resp_taken", 256'(resp_vld_o), 256'(0)); tick();

      // All four contending, table driven.
      do_reset();
      set_contenders();
      for (int r = 0; r < 12; r++) begin
         req_vld_i  = tbl[r].vld;
         resp_rdy_i = tbl[r].rr;
         step();
         check($sformatf("tbl%0d_rdy", r), 256'(req_rdy_o), 256'(tbl[r].rdy));
         check($sformatf("tbl%0d_rv", r), 256'(resp_vld_o), 256'(tbl[r].rv));
         for (int i = 0; i < N; i++)
            if (tbl[r].rv[i]) check($sformatf("tbl%0d_data%0d", r, i), 256'(resp_data_o[32*i +: 32]), 256'(tdat[i]));
         tick();
      end

      // Backpressure on requester 1.
      do_reset();
      set_contenders();
      resp_rdy_i = 4'b1101;
      for (int c = 0; c < 14; c++) begin
         step();
         if (c >= 4) begin
            check("bp_rdy1_blocked", 256'(req_rdy_o[1]), 256'(0));
            check("bp_slot1_stable", 256'({resp_vld_o[1], resp_data_o[63:32]}), 256'({1'b1, 32'h1234_5678}));
         end
         tick();
      end
      req_vld_i = 4'b0010;
      resp_rdy_i[1] = 1'b1;
      step(); check("bp_rdy1_accept_cycle", 256'(req_rdy_o[1]), 256'(0)); tick();
      resp_rdy_i = 4'b1111;
      step(); check("bp_rdy1_next_cycle", 256'(req_rdy_o[1]), 256'(1)); tick();
      req_vld_i = '0;
      repeat (6) cyc();

      // Fairness after requester 2 was served.
      do_reset();
      set_contenders();
      req_vld_i  = 4'b0100;
      resp_rdy_i = 4'b1111;
      step(); check("fair_grant2", 256'(req_rdy_o), 256'(4'b0100)); tick();
      req_vld_i = 4'b1010;
      step(); check("fair_3_before_1", 256'(req_rdy_o), 256'(4'b1000)); tick();
      step(); check("fair_1_after_3", 256'(req_rdy_o), 256'(4'b0010)); tick();
      req_vld_i = '0;
      repeat (6) cyc();

      // Randomised traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(req_vld_i[i] && !m_gvec[i])) begin
               if ($urandom_range(0, 2) != 0)
                  set_req(i, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, 32'($urandom_range(0, 40)), 3'($urandom_range(0, 7)));
               else
                  req_vld_i[i] = 1'b0;
            end
            resp_rdy_i[i] = 1'($urandom_range(0, 1));
         end
         cyc();
      end

      // Reset while S1/S2 hold ops and slot 0 is full.
      do_reset();
      set_contenders();
      req_vld_i = 4'b0001;
      cyc();
      req_vld_i = '0;
      cyc();
      req_vld_i = 4'b0010;
      cyc();
      req_vld_i = 4'b0100;
      step(); check("mid_slot0_full", 256'(resp_vld_o[0]), 256'(1)); tick();
      req_vld_i = 4'b0001;
      #1 rst_n = 1'b0;
      #1 check("mid_reset_outputs", all_outs(), 256'(0));
      tick();
      rst_n = 1'b1;
      model_reset();
      resp_rdy_i = 4'b1110;
      step(); check("mid_r0_first", 256'(req_rdy_o), 256'(4'b0001)); tick();
      req_vld_i = '0;
      repeat (6) cyc();

      // Spurious done with nothing in flight; slot 0 still full.
      force_done = 1'b1;
      cyc();
      force_done = 1'b0;
      step();
      check("perr_err_set", 256'(err_o), 256'(1));
      check("perr_resp_kept", 256'(resp_vld_o), 256'(4'b0001));
      tick();
      repeat (3) cyc();
      check("perr_err_sticky", 256'(err_o), 256'(1));

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
